alu_seq16: RTL and testbench
============================

# alu_seq16

16-bit add/subtract sequencer for the 8085 datapath. It produces 16-bit DAD/INX/DCX/register-pair results by driving the existing 8-bit ripple adder twice: low byte first, then high byte with the registered inter-byte carry. The block sits directly upstream of the 8-bit adder and owns its operand and carry-in inputs during a sequence. The adder itself is purely combinational and is instantiated outside this block.

## Interface
- DATASIZE, 8: adder slice width. The result width is 2*DATASIZE.

- iCLK  input  1  clock; all state changes on the rising edge
- iRST  input  1  asynchronous, active-low reset
- iSTART  input  1  request a sequence; sampled only in IDLE or DONE
- iOP  input  2  operation: 00 ADD (A+B), 01 INC (A+1), 10 DEC (A-1), 11 SUB (A-B)
- iA  input  16  operand A; captured on the accepting edge
- iB  input  16  operand B; captured on the accepting edge; ignored for INC/DEC
- oAA  output  8  to adder iA
- oAB  output  8  to adder iB
- oACI  output  1  to adder carry-in of bit 0
- iAS  input  8  adder sum
- iACO  input  1  adder carry out of the top bit (oC[DATASIZE-1])
- oRES  output  16  result; held until the next sequence completes
- oCY  output  1  carry for ADD/INC; borrow (inverted adder carry) for SUB/DEC
- oZ  output  1  set when oRES==0
- oBUSY  output  1  high in LOW and HIGH states
- oDONE  output  1  one-cycle pulse: result valid

## Operation
- States: IDLE, LOW, HIGH, DONE. A 2-bit encoding is sufficient.
- IDLE: if iSTART=1, capture iA, iB and iOP, then go to LOW. Otherwise stay in IDLE.
- LOW:
  - Drive the low bytes of the effective operands and the op carry-in.
  - On the edge, register iAS into the low-result register and iACO into the inter-byte carry register.
  - Go to HIGH.
- HIGH:
  - Drive the high bytes, with oACI set to the registered carry.
  - On the edge, update oRES as {iAS, low-result}.
  - Update oCY from iACO: iACO for ADD/INC, ~iACO for SUB/DEC.
  - Update oZ.
  - Go to DONE.
- DONE:
  - oDONE=1.
  - If iSTART=1, capture new operands and go to LOW (back-to-back operation). Otherwise go to IDLE.
- Effective B operand and op carry-in:
  - ADD: B, carry-in 0.
  - INC: 0x0000, carry-in 1.
  - DEC: 0xFFFF, carry-in 0.
  - SUB: ~B, carry-in 1.
- oAA, oAB and oACI are 0 in IDLE and DONE.
- iSTART is ignored in LOW and HIGH. No queuing.
- Arithmetic is modulo 2^16. oCY reflects only the bit-15 carry/borrow.
- iAS and iACO are used only in the LOW and HIGH cycles. Their values in other cycles have no effect.

## Timing
- Reset (iRST=0, asynchronous): state=IDLE, and oRES, oCY, oZ, oBUSY, oDONE, oAA, oAB, oACI and all internal registers are all 0.
- Reset mid-sequence aborts the sequence. No oDONE is produced, and the outputs take the reset values immediately.
- Release of iRST is synchronous to iCLK. The first possible accept is on the first rising edge with iRST=1.
- Latency: iSTART accepted at edge k → oBUSY=1 after edges k and k+1 → oRES, oCY, oZ valid and oDONE=1 after edge k+2 → oDONE=0 after edge k+3 unless restarted.
- Throughput: one result per 3 cycles when iSTART is held high.
- oRES, oCY and oZ change only on the HIGH→DONE edge or on reset.

## Test plan
- ADD 0x1234+0x0FCD. The low-byte carry must propagate into the high byte. → oRES=0x2201, oCY=0, oZ=0, oDONE exactly 3 edges after accept.
- ADD 0xFFFF+0x0001 → oRES=0x0000, oCY=1, oZ=1. INC 0x00FF → oRES=0x0100, oCY=0.
- DEC 0x0000 → oRES=0xFFFF, oCY=1 (borrow). SUB 0x5000-0x5000 → oRES=0x0000, oCY=0, oZ=1. SUB 0x0001-0x0002 → 0xFFFF, oCY=1.
- Pulse iSTART during LOW and HIGH with different operands → ignored. The first result completes unchanged, followed by a single oDONE pulse.
- Hold iSTART=1 with a stream of 4 ops → 4 oDONE pulses spaced 3 cycles apart, each with the correct result. Bench model checks oAA, oAB and oACI per cycle.
- Assert iRST=0 in HIGH → outputs 0 immediately, no oDONE. After release, a new ADD 0x0001+0x0001 → 0x0002.

Source files
------------

// File: rtl/alu_seq16.sv
// alu_seq16: sequences a 16-bit add/sub/inc/dec through an external 8-bit adder in two byte passes
module alu_seq16 #(
  parameter int DATASIZE = 8
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic [1:0]            iOP,
  input  logic [2*DATASIZE-1:0] iA,
  input  logic [2*DATASIZE-1:0] iB,
  output logic [DATASIZE-1:0]   oAA,
  output logic [DATASIZE-1:0]   oAB,
  output logic                  oACI,
  input  logic [DATASIZE-1:0]   iAS,
  input  logic                  iACO,
  output logic [2*DATASIZE-1:0] oRES,
  output logic                  oCY,
  output logic                  oZ,
  output logic                  oBUSY,
  output logic                  oDONE
);
  localparam int W = 2 * DATASIZE;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t              state_q, state_d;
  logic                accept;
  logic [W-1:0]        a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]          op_q, op_d;
  logic [DATASIZE-1:0] lo_q, lo_d;
  logic                c_q, c_d, cy_q, cy_d, z_q, z_d;
  // next state: capture operands with the effective B, then run low byte, high byte, done
  always_comb begin
    accept  = iSTART && (state_q == IDLE || state_q == DONE);
    state_d = accept ? LOW : state_q == LOW ? HIGH : state_q == HIGH ? DONE : IDLE;
    a_d     = accept ? iA : a_q;
    b_d     = accept ? (iOP == 2'b00 ? iB : iOP == 2'b01 ? '0 : iOP == 2'b10 ? '1 : ~iB) : b_q;
    op_d    = accept ? iOP : op_q;
    lo_d    = state_q == LOW ? iAS : lo_q;
    c_d     = state_q == LOW ? iACO : c_q;
    res_d   = state_q == HIGH ? {iAS, lo_q} : res_q;
    cy_d    = state_q == HIGH ? iACO ^ op_q[1] : cy_q;
    z_d     = state_q == HIGH ? ~|{iAS, lo_q} : z_q;
  end
  // state and datapath registers; reset aborts any sequence in flight
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      lo_q    <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      c_q     <= c_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
    end
  end
  // adder drive decoded from registered state; op carry-in is 1 exactly for INC and SUB
  always_comb begin
    oAA   = state_q == LOW ? a_q[DATASIZE-1:0] : state_q == HIGH ? a_q[W-1:DATASIZE] : '0;
    oAB   = state_q == LOW ? b_q[DATASIZE-1:0] : state_q == HIGH ? b_q[W-1:DATASIZE] : '0;
    oACI  = state_q == LOW ? op_q[0] : state_q == HIGH ? c_q : 1'b0;
    oBUSY = state_q == LOW || state_q == HIGH;
    oDONE = state_q == DONE;
    oRES  = res_q;
    oCY   = cy_q;
    oZ    = z_q;
  end
endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16: random and directed checks of alu_seq16 against a 16-bit arithmetic model
module tb_alu_seq16;
  logic        iCLK, iRST, iSTART;
  logic [1:0]  iOP;
  logic [15:0] iA, iB;
  logic [7:0]  oAA, oAB, iAS;
  logic        oACI, iACO;
  logic [15:0] oRES;
  logic        oCY, oZ, oBUSY, oDONE;
  int          total = 0, bad = 0, done_cnt = 0;

  alu_seq16 #(.DATASIZE(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iOP(iOP), .iA(iA), .iB(iB),
    .oAA(oAA), .oAB(oAB), .oACI(oACI), .iAS(iAS), .iACO(iACO),
    .oRES(oRES), .oCY(oCY), .oZ(oZ), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  // the external 8-bit ripple adder
  assign {iACO, iAS} = {1'b0, oAA} + {1'b0, oAB} + {8'd0, oACI};

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: ph counts cycles since accept (0 idle, 1 low pass, 2 high pass, 3 done)
  int          ph = 0;
  logic [15:0] ma = 0, mraw = 0, mb = 0, mr = 0;
  logic [1:0]  mop = 0;
  logic        mc = 0, mz = 0;
  logic [16:0] s17;
  always @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      ph = 0; ma = 0; mraw = 0; mb = 0; mop = 0; mr = 0; mc = 0; mz = 0;
    end else if (ph == 1) ph = 2;
    else if (ph == 2) begin
      case (mop)
        2'd0: begin s17 = {1'b0, ma} + {1'b0, mraw}; mr = s17[15:0]; mc = s17[16]; end
        2'd1: begin s17 = {1'b0, ma} + 17'd1; mr = s17[15:0]; mc = s17[16]; end
        2'd2: begin mr = ma - 16'd1; mc = (ma == 16'd0); end
        default: begin mr = ma - mraw; mc = (ma < mraw); end
      endcase
      mz = (mr == 16'd0);
      ph = 3;
    end else if (iSTART) begin
      ma = iA; mraw = iB; mop = iOP; ph = 1;
      mb = iOP == 2'd0 ? iB : iOP == 2'd1 ? 16'h0000 : iOP == 2'd2 ? 16'hFFFF : ~iB;
    end else ph = 0;
  end

  // every cycle compare all outputs against the model
  logic [8:0] lo9;
  always @(negedge iCLK) begin
    lo9 = {1'b0, ma[7:0]} + {1'b0, mb[7:0]} + {8'd0, mop[0]};
    chk("busy", 32'(oBUSY), 32'(ph == 1 || ph == 2));
    chk("done", 32'(oDONE), 32'(ph == 3));
    chk("res", 32'(oRES), 32'(mr));
    chk("cy", 32'(oCY), 32'(mc));
    chk("z", 32'(oZ), 32'(mz));
    chk("aa", 32'(oAA), 32'(ph == 1 ? ma[7:0] : ph == 2 ? ma[15:8] : 8'd0));
    chk("ab", 32'(oAB), 32'(ph == 1 ? mb[7:0] : ph == 2 ? mb[15:8] : 8'd0));
    chk("aci", 32'(oACI), 32'(ph == 1 ? mop[0] : ph == 2 ? lo9[8] : 1'b0));
    if (oDONE) done_cnt++;
  end

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ec, input logic ez);
    int n;
    iSTART = 1'b1; iOP = op; iA = a; iB = b;
    tick();
    iSTART = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!oDONE && n < 8);
    chk({name, "_lat"}, 32'(n), 32'd2);
    chk({name, "_res"}, 32'(oRES), 32'(er));
    chk({name, "_cy"}, 32'(oCY), 32'(ec));
    chk({name, "_z"}, 32'(oZ), 32'(ez));
    tick();
  endtask

  initial begin
    int d0;
    iRST = 1'b0; iSTART = 1'b0; iOP = 2'd0; iA = 16'd0; iB = 16'd0;
    #2;
    chk("rst_res", 32'(oRES), 32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    chk("rst_done", 32'(oDONE), 32'd0);
    chk("rst_aa", 32'({oAA, oAB, oACI}), 32'd0);
    #10 iRST = 1'b1;
    @(posedge iCLK); #1;
    do_op("add_c", 2'd0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
    do_op("add_wrap", 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    do_op("inc", 2'd1, 16'h00FF, 16'hBEEF, 16'h0100, 1'b0, 1'b0);
    do_op("dec0", 2'd2, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
    do_op("sub_eq", 2'd3, 16'h5000, 16'h5000, 16'h0000, 1'b0, 1'b1);
    do_op("sub_neg", 2'd3, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);
    // start held through LOW and HIGH with other operands must be ignored
    d0 = done_cnt;
    iSTART = 1'b1; iOP = 2'd0; iA = 16'h1234; iB = 16'h0FCD;
    tick();
    iOP = 2'd3; iA = 16'hAAAA; iB = 16'h5555;
    tick();
    tick();
    iSTART = 1'b0;
    chk("ign_res", 32'(oRES), 32'h2201);
    repeat (4) tick();
    chk("ign_pulses", 32'(done_cnt - d0), 32'd1);
    // back-to-back stream of 4 ops with start held high
    d0 = done_cnt;
    iSTART = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iOP = 2'($urandom_range(3)); iA = 16'($urandom); iB = 16'($urandom);
      repeat (3) tick();
    end
    iSTART = 1'b0;
    chk("stream_done", 32'(oDONE), 32'd1);
    repeat (2) tick();
    chk("stream_pulses", 32'(done_cnt - d0), 32'd4);
    // reset during the high pass aborts the sequence
    d0 = done_cnt;
    iSTART = 1'b1; iOP = 2'd0; iA = 16'h1111; iB = 16'h2222;
    tick();
    iSTART = 1'b0;
    tick();
    #2 iRST = 1'b0;
    #1;
    chk("abort_busy", 32'(oBUSY), 32'd0);
    chk("abort_aa", 32'({oAA, oAB, oACI}), 32'd0);
    chk("abort_res", 32'({oRES, oCY, oZ}), 32'd0);
    tick();
    tick();
    iRST = 1'b1;
    chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
    do_op("post_rst", 2'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    // random traffic, including starts while busy, checked every cycle by the model
    for (int i = 0; i < 300; i++) begin
      iSTART = ($urandom_range(2) != 0);
      iOP = 2'($urandom_range(3));
      iA = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      iB = ($urandom_range(7) == 0) ? iA : 16'($urandom);
      tick();
    end
    iSTART = 1'b0;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
